four_bit_sequencer: RTL
=======================

FOUR_BIT_SEQUENCER -- requirements
Module: four_bit_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 8'd25, program start address loaded into PC on reset and on restart.
REQ-002 Parameter STACK_DEPTH, 4, number of return-address entries (fixed 4; sp is 3 bits).
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Rst_n  in  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-005 start  in  1  begin execution; honoured only in IDLE or HALT.
REQ-006 rom_addr  out  8  registered program address, equal to PC.
REQ-007 rom_data  in  8  instruction byte, valid the cycle after rom_addr is driven; opcode = [7:4], operand = [3:0].
REQ-008 alu_start  out  1  one-cycle pulse issuing an operation to the datapath.
REQ-009 alu_op  out  4  datapath opcode, held from ISSUE until alu_done.
REQ-010 alu_operand  out  4  immediate nibble, held with alu_op.
REQ-011 alu_done  in  1  datapath completion strobe.
REQ-012 zf  in  1  datapath zero flag, sampled only for JZ.
REQ-013 busy  out  1  high in every state except IDLE, HALT and ERROR.
REQ-014 halted  out  1  high in HALT.
REQ-015 stack_err  out  1  high in ERROR.
REQ-016 sp  out  3  return-stack occupancy, 0..4.

Function
REQ-017 States: IDLE, FETCH, DECODE, ISSUE, WAIT_ALU, FETCH_T, LOAD_T, HALT, ERROR; one transition per clock maximum.
REQ-018 Opcode map: 0x0 NOP; 0x1-0xB ALU ops (ADD, SUB, XCHG, MOV, RCR, IN, OUT, AND, TEST, OR, XOR); 0xC JMP; 0xD JZ; 0xE CALL; 0xF0 RET; 0xFF HLT; other 0xF_ values behave as NOP.
REQ-019 IDLE: start=1 -> FETCH.
REQ-020 FETCH: drive rom_addr=PC -> DECODE.
REQ-021 DECODE: latch rom_data into IR.
- NOP: PC+1 -> FETCH.
- ALU op: -> ISSUE.
- JMP/JZ/CALL: PC+1 -> FETCH_T.
- RET with sp=0: -> ERROR.
- RET with sp>0: PC <= stack[sp-1], sp-1 -> FETCH.
- HLT: -> HALT, PC unchanged.
REQ-022 ISSUE: alu_start=1 for exactly this cycle; alu_op=IR[7:4], alu_operand=IR[3:0]; PC+1 -> WAIT_ALU.
REQ-023 WAIT_ALU: alu_done=1 -> FETCH, else remain; alu_done during ISSUE or any other state is ignored.
REQ-024 FETCH_T: drive rom_addr=PC, which addresses the target byte -> LOAD_T.
REQ-025 LOAD_T: T=rom_data.
- JMP: PC <= T.
- JZ: PC <= T if zf=1, else PC+1.
- CALL with sp=4: -> ERROR, PC and stack unchanged.
- CALL with sp<4: stack[sp] <= PC+1, sp+1, PC <= T.
- All cases without error: -> FETCH.
REQ-026 PC arithmetic is modulo 256 (0xFF+1=0x00); a two-byte instruction at 0xFF takes its target byte from 0x00.
REQ-027 HALT: start=1 -> PC <= RESET_VECTOR, sp <= 0 -> FETCH; otherwise remain.
REQ-028 ERROR: sticky; exit only by reset; start is ignored.
REQ-029 start is ignored in every state except IDLE and HALT.

Reset
REQ-030 Rst_n=0 at any posedge, including mid-ISSUE or mid-WAIT_ALU, forces IDLE on that edge.
REQ-031 Reset values: PC=rom_addr=RESET_VECTOR, sp=0, IR=0, alu_start=0, alu_op=0, alu_operand=0, busy=0, halted=0, stack_err=0.
REQ-032 Stack contents are not reset; entries are never read while sp=0.

Verification
REQ-033 ALU and halt: ROM[25]=0x12, ROM[26]=0xFF; start pulse; alu_done two cycles after alu_start -> alu_start high in the third cycle after start is sampled, op=1, operand=2; then rom_addr=26 and halted=1.
REQ-034 JZ: ROM[25]=0xD0, ROM[26]=0x40 -> zf=1 gives next fetch at 0x40; zf=0 gives next fetch at 27.
REQ-035 CALL/RET: ROM[25]=0xE0, ROM[26]=0x80, ROM[0x80]=0xF0 -> sp goes 1 then 0; next fetch after RET is 27.
REQ-036 Overflow and underflow:
- Five nested CALLs -> stack_err=1, sp=4, busy=0.
- RET as the first instruction -> stack_err=1, sp=0.
REQ-037 Reset mid-op: Rst_n low for one cycle in WAIT_ALU -> after that edge alu_start=0, busy=0, rom_addr=25, sp=0; a later alu_done is ignored.
REQ-038 Wrap: RESET_VECTOR=0xFF, ROM[0xFF]=0x00 -> next rom_addr=0x00.

Source files
------------

// File: rtl/four_bit_sequencer_if.sv
// Purpose: program-ROM and ALU handshake bundle between the sequencer and its datapath.
// Latency: ROM answers the cycle after rom_addr; the ALU answers with alu_done after any delay.
// Backpressure: alu_done is the only stall; ROM has no flow control.
interface four_bit_sequencer_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       alu_start;
    logic [3:0] alu_op;
    logic [3:0] alu_operand;
    logic       alu_done;
    logic       zf;

    modport master (
        output rom_addr, alu_start, alu_op, alu_operand,
        input  rom_data, alu_done, zf
    );

    modport slave (
        input  rom_addr, alu_start, alu_op, alu_operand,
        output rom_data, alu_done, zf
    );
endinterface

// File: rtl/four_bit_sequencer.sv
// Purpose: 4-bit microsequencer fetching byte opcodes, issuing ALU ops, jumps, calls and returns.
// Latency: 2 cycles per one-byte op, 4 per branch/call, ALU ops add the datapath's alu_done delay.
// Backpressure: holds in WAIT_ALU until alu_done; start is honoured only in IDLE or HALT.
module four_bit_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'd25,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 start,
    four_bit_sequencer_if.master bus,
    output logic                 busy,
    output logic                 halted,
    output logic                 stack_err,
    output logic [2:0]           sp
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ALU,
        S_FETCH_T,
        S_LOAD_T,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [7:0] INS_RET = 8'hF0;
    localparam logic [7:0] INS_HLT = 8'hFF;
    localparam logic [2:0] SP_FULL = 3'(STACK_DEPTH);

    state_t     state;
    state_t     state_nx;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       alu_start_q;
    logic [7:0] stack [STACK_DEPTH];

    logic [3:0] dec_op;
    logic       dec_alu;
    logic       dec_branch;
    logic [1:0] top_idx;
    logic [7:0] pc_inc;
    logic       call_ok;

    assign dec_op     = bus.rom_data[7:4];
    assign dec_alu    = (dec_op != OP_NOP) && (dec_op < OP_JMP);
    assign dec_branch = (dec_op == OP_JMP) || (dec_op == OP_JZ) || (dec_op == OP_CALL);
    assign top_idx    = sp[1:0] - 2'd1;
    assign pc_inc     = pc + 8'd1;
    assign call_ok    = (sp != SP_FULL);

    // IR only changes in DECODE, so the operation stays stable from ISSUE through alu_done.
    assign bus.rom_addr    = pc;
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_op      = ir[7:4];
    assign bus.alu_operand = ir[3:0];

    function automatic logic [2:0] status_of(input state_t s);
        return {(s != S_IDLE) && (s != S_HALT) && (s != S_ERROR), s == S_HALT, s == S_ERROR};
    endfunction

    // Next-state selection; at most one transition per clock.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start) state_nx = S_FETCH;
            S_FETCH:    state_nx = S_DECODE;
            S_DECODE: begin
                if (dec_alu)                      state_nx = S_ISSUE;
                else if (dec_branch)              state_nx = S_FETCH_T;
                else if (bus.rom_data == INS_RET) state_nx = (sp == 3'd0) ? S_ERROR : S_FETCH;
                else if (bus.rom_data == INS_HLT) state_nx = S_HALT;
                else                              state_nx = S_FETCH;
            end
            S_ISSUE:    state_nx = S_WAIT_ALU;
            S_WAIT_ALU: if (bus.alu_done) state_nx = S_FETCH;
            S_FETCH_T:  state_nx = S_LOAD_T;
            S_LOAD_T:   state_nx = (ir[7:4] == OP_CALL && !call_ok) ? S_ERROR : S_FETCH;
            S_HALT:     if (start) state_nx = S_FETCH;
            S_ERROR:    state_nx = S_ERROR;
            default:    state_nx = S_IDLE;
        endcase
    end

    // State register, PC/IR/stack pointer updates and registered status outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_VECTOR;
            ir          <= '0;
            sp          <= '0;
            alu_start_q <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            state                     <= state_nx;
            {busy, halted, stack_err} <= status_of(state_nx);
            alu_start_q               <= (state_nx == S_ISSUE);
            case (state)
                S_DECODE: begin
                    ir <= bus.rom_data;
                    if (bus.rom_data == INS_RET) begin
                        if (sp != 3'd0) begin
                            pc <= stack[top_idx];
                            sp <= sp - 3'd1;
                        end
                    end else if (bus.rom_data != INS_HLT && !dec_alu) begin
                        // NOP, undefined 0xF_ and the first byte of two-byte ops
                        pc <= pc_inc;
                    end
                end
                S_ISSUE: pc <= pc_inc;
                S_LOAD_T: begin
                    case (ir[7:4])
                        OP_JMP:  pc <= bus.rom_data;
                        OP_JZ:   pc <= bus.zf ? bus.rom_data : pc_inc;
                        OP_CALL: begin
                            if (call_ok) begin
                                pc <= bus.rom_data;
                                sp <= sp + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_HALT: begin
                    if (start) begin
                        pc <= RESET_VECTOR;
                        sp <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Return stack storage; contents are don't-care until pushed.
    always_ff @(posedge Clk) begin
        if (Rst_n && state == S_LOAD_T && ir[7:4] == OP_CALL && call_ok)
            stack[sp[1:0]] <= pc_inc;
    end

endmodule
